// File: rtl/segment_scanner.sv
// segment_scanner: time-multiplexes two 8-bit segment patterns onto a shared
// segment bus with a one-hot digit enable and a per-frame completion pulse.
//
// Build option: define SCAN_BLANK_EN to insert GAP_CYCLES blanking cycles
// after each digit (DIGIT0 -> GAP0 -> DIGIT1 -> GAP1). Without it the digits
// alternate back to back and GAP_CYCLES has no functional effect.
//
// All outputs are registered and are computed from the next state, so they
// change on the same edge as the state register. Segment patterns are taken
// into shadow registers on DIGIT0 entry so one frame shows a single capture.

module segment_scanner #(
    parameter int unsigned SCAN_DIV   = 1000,   // cycles each digit is lit
    parameter int unsigned GAP_CYCLES = 16,     // blanking cycles between digits
    parameter logic [7:0]  SEG_OFF    = 8'hFF   // bus value while no digit is lit
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] Segment_0,
    input  logic [7:0] Segment_1,
    output logic [7:0] Seg_Out,
    output logic [1:0] Digit_En,
    output logic       Frame_Done
);

    // Counter holds at most (longest phase - 1); size it for the larger phase.
    localparam int unsigned MaxLoad = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int unsigned CntW    = (MaxLoad > 2) ? $clog2(MaxLoad) : 1;

    localparam logic [CntW-1:0] DivLoad = CntW'(SCAN_DIV - 1);

`ifdef SCAN_BLANK_EN
    localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDigit0,
        StGap0,
        StDigit1,
        StGap1
    } state_e;

    // Frame_Done marks the last cycle spent in this state.
    localparam state_e LastState = StGap1;
`else
    typedef enum logic [1:0] {
        StIdle,
        StDigit0,
        StDigit1
    } state_e;

    localparam state_e LastState = StDigit1;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      shadow0_q, shadow0_d;
    logic [7:0]      shadow1_q, shadow1_d;
    logic [7:0]      seg_q, seg_d;
    logic [1:0]      digit_en_q, digit_en_d;
    logic            done_q, done_d;

    // Next-state logic: phase sequencing, counter reload and shadow capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;

        if (!Enable) begin
            // Dropping Enable aborts the frame immediately from any state.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StDigit0;
                    cnt_d     = DivLoad;
                    shadow0_d = Segment_0;
                    shadow1_d = Segment_1;
                end
                StDigit0: begin
                    if (cnt_q == '0) begin
`ifdef SCAN_BLANK_EN
                        state_d = StGap0;
                        cnt_d   = GapLoad;
`else
                        state_d = StDigit1;
                        cnt_d   = DivLoad;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef SCAN_BLANK_EN
                StGap0: begin
                    if (cnt_q == '0) begin
                        state_d = StDigit1;
                        cnt_d   = DivLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDigit1: begin
                    if (cnt_q == '0) begin
                        state_d = StGap1;
                        cnt_d   = GapLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StGap1: begin
                    if (cnt_q == '0) begin
                        state_d   = StDigit0;
                        cnt_d     = DivLoad;
                        shadow0_d = Segment_0;
                        shadow1_d = Segment_1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`else
                StDigit1: begin
                    if (cnt_q == '0) begin
                        state_d   = StDigit0;
                        cnt_d     = DivLoad;
                        shadow0_d = Segment_0;
                        shadow1_d = Segment_1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs register alongside it.
    always_comb begin
        seg_d      = SEG_OFF;
        digit_en_d = 2'b00;
        done_d     = 1'b0;

        unique case (state_d)
            StDigit0: begin
                seg_d      = shadow0_d;
                digit_en_d = 2'b01;
            end
            StDigit1: begin
                seg_d      = shadow1_d;
                digit_en_d = 2'b10;
            end
            default: begin
                seg_d      = SEG_OFF;
                digit_en_d = 2'b00;
            end
        endcase

        // Last cycle of the last phase: counter has reached zero there.
        done_d = (state_d == LastState) && (cnt_d == '0);
    end

    // State, counter, shadow and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shadow0_q  <= SEG_OFF;
            shadow1_q  <= SEG_OFF;
            seg_q      <= SEG_OFF;
            digit_en_q <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow0_q  <= shadow0_d;
            shadow1_q  <= shadow1_d;
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
            done_q     <= done_d;
        end
    end

    assign Seg_Out    = seg_q;
    assign Digit_En   = digit_en_q;
    assign Frame_Done = done_q;

endmodule
